// File: rtl/reg_pkg.sv
// Register-file write-port type plus the writeback buffer entry carried from
// functional units to the register file.
package reg_pkg;
    localparam int WORD_SIZE     = rob_pkg::WORD_SIZE;
    localparam int PREG_W        = $clog2(rob_pkg::NUM_PHYS_REGS);
    localparam int ROB_ID_W      = $clog2(rob_pkg::ROB_ENTRIES);
    localparam int WB_FIFO_DEPTH = 2;

    typedef struct packed {
        logic                 we;
        logic [PREG_W-1:0]    addr;
        logic [WORD_SIZE-1:0] data;
    } RegFileWritePort;

    typedef struct packed {
        logic [PREG_W-1:0]    preg;
        logic [WORD_SIZE-1:0] data;
        logic [ROB_ID_W-1:0]  rob_id;
    } WbEntry;
endpackage

// File: rtl/rob_pkg.sv
// Reorder-buffer sizing shared by the back end; the writeback path derives
// its tag and data widths from here.
package rob_pkg;
    localparam int WORD_SIZE     = 32;
    localparam int NUM_PHYS_REGS = 64;
    localparam int ROB_ENTRIES   = 32;
endpackage

// File: rtl/wb_skid_fifo.sv
// Two-entry FIFO holding one functional unit's pending writeback results.
// Callers only push when not full and only pop when not empty.
module wb_skid_fifo
    import reg_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  WbEntry push_entry,
    input  logic   pop,
    output logic   full,
    output logic   empty,
    output WbEntry head
);
    logic [1:0] count_q, count_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    WbEntry     mem_q [WB_FIFO_DEPTH];
    WbEntry     mem_d [WB_FIFO_DEPTH];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    assign full  = (count_q == 2'(WB_FIFO_DEPTH));
    assign empty = (count_q == 2'd0);
    assign head  = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: an empty FIFO never exposes its contents.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: buffers functional-unit results and grants up to
// NUM_WRITE_PORTS of them per cycle round-robin onto registered RF ports.
module wb_arbiter
    import reg_pkg::*;
#(
    parameter  int NUM_FU          = 4,
    parameter  int NUM_WRITE_PORTS = 2,
    localparam int FU_W            = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic            [NUM_FU-1:0]             fu_valid,
    output logic            [NUM_FU-1:0]             fu_ready,
    input  logic            [NUM_FU-1:0][PREG_W-1:0] fu_preg,
    input  logic            [NUM_FU-1:0][WORD_SIZE-1:0] fu_data,
    input  logic            [NUM_FU-1:0][ROB_ID_W-1:0]  fu_rob_id,
    output RegFileWritePort [NUM_WRITE_PORTS-1:0]    write_ports,
    output logic            [NUM_WRITE_PORTS-1:0]    cmpl_valid,
    output logic            [NUM_WRITE_PORTS-1:0][ROB_ID_W-1:0] cmpl_rob_id,
    output logic            [FU_W-1:0]               dbg_rr_ptr
);
    localparam int CNT_W = $clog2(NUM_WRITE_PORTS + 1);

    logic [NUM_FU-1:0] fifo_full, fifo_empty, grant;
    WbEntry            fifo_head [NUM_FU];

    logic [FU_W-1:0]   rr_ptr_q, rr_ptr_d;
    RegFileWritePort [NUM_WRITE_PORTS-1:0] wp_q, wp_d;
    logic [NUM_WRITE_PORTS-1:0]            cmpl_valid_q, cmpl_valid_d;
    logic [NUM_WRITE_PORTS-1:0][ROB_ID_W-1:0] cmpl_rob_id_q, cmpl_rob_id_d;

    // Handshake: a result transfers on a cycle where fu_valid && fu_ready;
    // fu_ready depends only on the registered occupancy, and a source seeing
    // valid without ready must hold its result unchanged until it transfers.
    for (genvar i = 0; i < NUM_FU; i++) begin : g_fifo
        wb_skid_fifo u_fifo (
            .clk        (clk),
            .rst        (rst),
            .push       (fu_valid[i] && !fifo_full[i]),
            .push_entry ('{preg: fu_preg[i], data: fu_data[i], rob_id: fu_rob_id[i]}),
            .pop        (grant[i]),
            .full       (fifo_full[i]),
            .empty      (fifo_empty[i]),
            .head       (fifo_head[i])
        );
        assign fu_ready[i] = !fifo_full[i];
    end

    always_comb begin
        logic [CNT_W-1:0] n;
        logic [FU_W-1:0]  idx;
        logic [FU_W-1:0]  last;
        grant         = '0;
        wp_d          = '0;
        cmpl_valid_d  = '0;
        cmpl_rob_id_d = '0;
        n             = '0;
        idx           = '0;
        last          = rr_ptr_q;
        for (int k = 0; k < NUM_FU; k++) begin
            idx = FU_W'((int'(rr_ptr_q) + k) % NUM_FU);
            if (!fifo_empty[idx] && (int'(n) < NUM_WRITE_PORTS)) begin
                grant[idx] = 1'b1;
                last       = idx;
                for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
                    if (n == CNT_W'(p)) begin
                        wp_d[p]          = '{we: 1'b1, addr: fifo_head[idx].preg,
                                             data: fifo_head[idx].data};
                        cmpl_valid_d[p]  = 1'b1;
                        cmpl_rob_id_d[p] = fifo_head[idx].rob_id;
                    end
                end
                n = n + CNT_W'(1);
            end
        end
        rr_ptr_d = (|grant) ? FU_W'((int'(last) + 1) % NUM_FU) : rr_ptr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q      <= '0;
            wp_q          <= '0;
            cmpl_valid_q  <= '0;
            cmpl_rob_id_q <= '0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            wp_q          <= wp_d;
            cmpl_valid_q  <= cmpl_valid_d;
            cmpl_rob_id_q <= cmpl_rob_id_d;
        end
    end

    assign write_ports = wp_q;
    assign cmpl_valid  = cmpl_valid_q;
    assign cmpl_rob_id = cmpl_rob_id_q;
    assign dbg_rr_ptr  = rr_ptr_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed vectors, corner sequences and
// random streaming compared against a queue-based reference model.
module tb_wb_arbiter;
    import reg_pkg::*;

    localparam int NF = 4;
    localparam int NP = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [NF-1:0]                 fu_valid, fu_ready;
    logic [NF-1:0][PREG_W-1:0]     fu_preg;
    logic [NF-1:0][WORD_SIZE-1:0]  fu_data;
    logic [NF-1:0][ROB_ID_W-1:0]   fu_rob_id;
    RegFileWritePort [NP-1:0]      write_ports;
    logic [NP-1:0]                 cmpl_valid;
    logic [NP-1:0][ROB_ID_W-1:0]   cmpl_rob_id;
    logic [1:0]                    dbg_rr_ptr;

    wb_arbiter #(.NUM_FU(NF), .NUM_WRITE_PORTS(NP)) dut (
        .clk        (clk),
        .rst        (rst),
        .fu_valid   (fu_valid),
        .fu_ready   (fu_ready),
        .fu_preg    (fu_preg),
        .fu_data    (fu_data),
        .fu_rob_id  (fu_rob_id),
        .write_ports(write_ports),
        .cmpl_valid (cmpl_valid),
        .cmpl_rob_id(cmpl_rob_id),
        .dbg_rr_ptr (dbg_rr_ptr)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: one list of pending results tagged with their source;
    // a source's oldest entry is its first occurrence in the list.
    typedef struct {
        int                   src;
        logic [PREG_W-1:0]    preg;
        logic [WORD_SIZE-1:0] data;
        logic [ROB_ID_W-1:0]  rob;
    } ent_t;

    ent_t                 mq[$];
    int                   m_rr = 0;
    logic [NP-1:0]        e_we = '0;
    logic [PREG_W-1:0]    e_addr [NP];
    logic [WORD_SIZE-1:0] e_data [NP];
    logic [ROB_ID_W-1:0]  e_rob  [NP];
    logic [NF-1:0]        acc = '0;
    int                   seq [NF];
    logic [ROB_ID_W-1:0]  exp_q[$];

    function automatic int m_count(input int s);
        int c = 0;
        foreach (mq[j]) if (mq[j].src == s) c++;
        return c;
    endfunction

    task automatic model_clear_outputs();
        e_we = '0;
        for (int p = 0; p < NP; p++) begin
            e_addr[p] = '0;
            e_data[p] = '0;
            e_rob[p]  = '0;
        end
    endtask

    task automatic tick();
        int   ng;
        int   last;
        int   s;
        bit   found;
        ent_t e;
        acc = '0;
        if (rst) begin
            mq.delete();
            m_rr = 0;
            model_clear_outputs();
        end else begin
            for (int s0 = 0; s0 < NF; s0++) acc[s0] = fu_valid[s0] && (m_count(s0) < WB_FIFO_DEPTH);
            model_clear_outputs();
            ng   = 0;
            last = 0;
            for (int k = 0; k < NF; k++) begin
                s = (m_rr + k) % NF;
                if (ng < NP && m_count(s) > 0) begin
                    found = 0;
                    for (int j = 0; j < mq.size(); j++) begin
                        if (!found && mq[j].src == s) begin
                            e = mq[j];
                            mq.delete(j);
                            found = 1;
                        end
                    end
                    e_we[ng]   = 1'b1;
                    e_addr[ng] = e.preg;
                    e_data[ng] = e.data;
                    e_rob[ng]  = e.rob;
                    ng++;
                    last = s;
                end
            end
            if (ng > 0) m_rr = (last + 1) % NF;
            for (int s0 = 0; s0 < NF; s0++) begin
                if (acc[s0]) mq.push_back('{src: s0, preg: fu_preg[s0], data: fu_data[s0], rob: fu_rob_id[s0]});
            end
        end
        @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++) begin
            check($sformatf("model port%0d", p),
                  {write_ports[p].we, cmpl_valid[p], write_ports[p].addr, write_ports[p].data, cmpl_rob_id[p]},
                  {e_we[p], e_we[p], e_addr[p], e_data[p], e_rob[p]});
        end
        for (int s0 = 0; s0 < NF; s0++) check($sformatf("model fu_ready%0d", s0), fu_ready[s0], m_count(s0) < WB_FIFO_DEPTH);
        check("model rr_ptr", dbg_rr_ptr, m_rr);
    endtask

    task automatic check_port(input string tag, input int p, input logic we,
                              input logic [PREG_W-1:0] addr, input logic [WORD_SIZE-1:0] data,
                              input logic [ROB_ID_W-1:0] rob);
        check($sformatf("%s port%0d", tag, p),
              {write_ports[p].we, cmpl_valid[p], write_ports[p].addr, write_ports[p].data, cmpl_rob_id[p]},
              {we, we, addr, data, rob});
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        fu_valid = '0;
        tick();
        rst = 1'b0;
        check_port("reset", 0, 1'b0, '0, '0, '0);
        check_port("reset", 1, 1'b0, '0, '0, '0);
        check("reset fu_ready", fu_ready, 4'hF);
        check("reset rr_ptr", dbg_rr_ptr, 2'd0);
    endtask

    task automatic drive(input int s, input logic [PREG_W-1:0] preg,
                         input logic [WORD_SIZE-1:0] data, input logic [ROB_ID_W-1:0] rob);
        fu_valid[s]  = 1'b1;
        fu_preg[s]   = preg;
        fu_data[s]   = data;
        fu_rob_id[s] = rob;
    endtask

    // Source id lives in preg[5:4] so outputs can be attributed to a source.
    task automatic gen(input int s, input bit on);
        fu_valid[s]  = on;
        fu_preg[s]   = {2'(s), 4'(seq[s])};
        fu_data[s]   = $urandom;
        fu_rob_id[s] = ROB_ID_W'(seq[s]);
        seq[s]++;
    endtask

    task automatic refill(input logic [NF-1:0] mask, input bit rnd);
        for (int s = 0; s < NF; s++) begin
            if (acc[s] || !fu_valid[s]) gen(s, rnd ? ($urandom_range(0, 3) != 0) : mask[s]);
        end
    endtask

    typedef struct {
        int                   fu;
        logic [PREG_W-1:0]    preg;
        logic [WORD_SIZE-1:0] data;
        logic [ROB_ID_W-1:0]  rob;
        logic [PREG_W-1:0]    exp_addr;
        logic [WORD_SIZE-1:0] exp_data;
        logic [ROB_ID_W-1:0]  exp_rob;
    } vec_t;

    vec_t vecs[4];
    int   cnt[NF];
    logic [7:0] fair_v;
    bit   seen_not_ready;

    initial begin
        fu_valid  = '0;
        fu_preg   = '0;
        fu_data   = '0;
        fu_rob_id = '0;
        for (int s = 0; s < NF; s++) seq[s] = 0;
        model_clear_outputs();

        vecs[0] = '{fu: 2, preg: 6'd17, data: 32'hDEAD,     rob: 5'd5,  exp_addr: 6'd17, exp_data: 32'hDEAD,     exp_rob: 5'd5};
        vecs[1] = '{fu: 0, preg: 6'd63, data: 32'hFFFFFFFF, rob: 5'd31, exp_addr: 6'd63, exp_data: 32'hFFFFFFFF, exp_rob: 5'd31};
        vecs[2] = '{fu: 3, preg: 6'd0,  data: 32'h0,        rob: 5'd0,  exp_addr: 6'd0,  exp_data: 32'h0,        exp_rob: 5'd0};
        vecs[3] = '{fu: 1, preg: 6'd42, data: 32'h12345678, rob: 5'd17, exp_addr: 6'd42, exp_data: 32'h12345678, exp_rob: 5'd17};

        // Single result: latency of two cycles, always on port 0.
        for (int v = 0; v < 4; v++) begin
            do_reset();
            drive(vecs[v].fu, vecs[v].preg, vecs[v].data, vecs[v].rob);
            tick();
            fu_valid = '0;
            check_port($sformatf("single%0d c1", v), 0, 1'b0, '0, '0, '0);
            tick();
            check_port($sformatf("single%0d c2", v), 0, 1'b1, vecs[v].exp_addr, vecs[v].exp_data, vecs[v].exp_rob);
            check_port($sformatf("single%0d c2", v), 1, 1'b0, '0, '0, '0);
        end

        // Four simultaneous results.
        do_reset();
        for (int s = 0; s < NF; s++) drive(s, PREG_W'(10 + s), 32'(100 + s), ROB_ID_W'(s));
        tick();
        fu_valid = '0;
        tick();
        check_port("four c2", 0, 1'b1, 6'd10, 32'd100, 5'd0);
        check_port("four c2", 1, 1'b1, 6'd11, 32'd101, 5'd1);
        check("four c2 rr_ptr", dbg_rr_ptr, 2'd2);
        tick();
        check_port("four c3", 0, 1'b1, 6'd12, 32'd102, 5'd2);
        check_port("four c3", 1, 1'b1, 6'd13, 32'd103, 5'd3);
        check("four c3 rr_ptr", dbg_rr_ptr, 2'd0);
        tick();
        check_port("four c4", 0, 1'b0, '0, '0, '0);

        // Push and pop on the same FIFO in the same cycle.
        do_reset();
        drive(1, 6'd5, 32'hAAAA, 5'd1);
        tick();
        drive(1, 6'd6, 32'hBBBB, 5'd2);
        tick();
        fu_valid = '0;
        check_port("pushpop c2", 0, 1'b1, 6'd5, 32'hAAAA, 5'd1);
        check("pushpop fu_ready1", fu_ready[1], 1'b1);
        tick();
        check_port("pushpop c3", 0, 1'b1, 6'd6, 32'hBBBB, 5'd2);
        tick();
        check_port("pushpop c4", 0, 1'b0, '0, '0, '0);

        // Reset with three results buffered flushes them.
        do_reset();
        for (int s = 0; s < 3; s++) drive(s, PREG_W'(20 + s), 32'(200 + s), ROB_ID_W'(8 + s));
        tick();
        fu_valid = '0;
        rst      = 1'b1;
        tick();
        rst = 1'b0;
        check("flush we", {write_ports[1].we, write_ports[0].we, cmpl_valid}, 4'b0);
        check("flush fu_ready", fu_ready, 4'hF);
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("flush idle%0d we", c), {write_ports[1].we, write_ports[0].we, cmpl_valid}, 4'b0);
        end

        // Fairness: all sources kept non-empty, each granted once per two cycles.
        do_reset();
        refill(4'hF, 0);
        tick();
        refill(4'hF, 0);
        for (int s = 0; s < NF; s++) cnt[s] = 0;
        for (int c = 0; c < 100; c++) begin
            tick();
            for (int p = 0; p < NP; p++) if (write_ports[p].we) cnt[write_ports[p].addr[5:4]]++;
            if (c % 2 == 1) begin
                for (int s = 0; s < NF; s++) fair_v[2*s +: 2] = 2'((cnt[s] > 3) ? 3 : cnt[s]);
                check($sformatf("fair window%0d", c / 2), fair_v, 8'h55);
                for (int s = 0; s < NF; s++) cnt[s] = 0;
            end
            refill(4'hF, 0);
        end

        // Back-pressure: FU0 overdriven, its rob_id order must be preserved.
        do_reset();
        exp_q.delete();
        seen_not_ready = 0;
        refill(4'hF, 0);
        for (int c = 0; c < 60; c++) begin
            tick();
            for (int p = 0; p < NP; p++) begin
                if (write_ports[p].we && write_ports[p].addr[5:4] == 2'd0) begin
                    if (exp_q.size() == 0) check("bp fu0 unexpected", 1'b1, 1'b0);
                    else check("bp fu0 order", cmpl_rob_id[p], exp_q.pop_front());
                end
            end
            if (acc[0]) exp_q.push_back(fu_rob_id[0]);
            if (!fu_ready[0]) seen_not_ready = 1;
            refill((c < 40) ? 4'hF : 4'h0, 0);
        end
        check("bp fu_ready0 dropped", seen_not_ready, 1'b1);
        check("bp fu0 all delivered", exp_q.size(), 0);

        // Random streaming against the reference model.
        do_reset();
        refill(4'h0, 1);
        for (int c = 0; c < 400; c++) begin
            tick();
            refill(4'h0, (c < 380));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter sitting directly upstream of the physical register file's write ports. It collects results from `NUM_FU` functional units through per-unit 2-entry skid buffers, selects up to `NUM_WRITE_PORTS` results per cycle round-robin, and drives registered register-file write ports plus matching ROB completion signals. It decouples functional units from write-port contention through back-pressure.

## Interface
- `WORD_SIZE`, `rob_pkg::WORD_SIZE`, result data width.
- `NUM_PHYS_REGS`, `rob_pkg::NUM_PHYS_REGS`, physical register count; `PREG_W = $clog2(NUM_PHYS_REGS)`.
- `ROB_ID_W`, `$clog2(rob_pkg::ROB_ENTRIES)`, ROB tag width.
- `NUM_FU`, 4, number of result sources.
- `NUM_WRITE_PORTS`, 2, register-file write ports driven.
- `clk  in  1`: single clock; all state updates on the rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `fu_valid  in  [NUM_FU]`: source result valid.
- `fu_ready  out  [NUM_FU]`: buffer can accept.
- `fu_preg  in  [NUM_FU][PREG_W]`: destination physical register.
- `fu_data  in  [NUM_FU][WORD_SIZE]`: result value.
- `fu_rob_id  in  [NUM_FU][ROB_ID_W]`: ROB tag.
- `write_ports  out  RegFileWritePort[NUM_WRITE_PORTS]`: `{we, addr, data}` to the register file.
- `cmpl_valid  out  [NUM_WRITE_PORTS]`: completion to the ROB, aligned with `write_ports[i].we`.
- `cmpl_rob_id  out  [NUM_WRITE_PORTS][ROB_ID_W]`: completing tag.

## Operation
- Per source: 2-entry FIFO of `{preg, data, rob_id}` with count 0..2. `fu_ready[i] = (count < 2)`, a function of registered count only, with no same-cycle pop bypass.
- Enqueue when `fu_valid[i] && fu_ready[i]`. If `fu_valid` is high while not ready, the source holds its data; nothing is dropped.
- Arbitration (combinational, on FIFO heads):
  - Scan sources starting at `rr_ptr`, wrapping modulo `NUM_FU`.
  - The first non-empty source goes to port 0, the second to port 1, and so on, up to `NUM_WRITE_PORTS` grants.
  - Granted heads pop this cycle.
- Pointer update: `rr_ptr <= (last granted index + 1) mod NUM_FU`. With no grant, `rr_ptr` is unchanged.
- Simultaneous push and pop on one FIFO: count is unchanged and order is preserved (FIFO).
- A source gets at most one grant per cycle.
- Output registers per port `i`:
  - `write_ports[i].we` and `cmpl_valid[i]` are equal.
  - `addr`, `data` and `cmpl_rob_id` come from the granted head.
  - Ungranted ports have `we = 0`, `cmpl_valid = 0`, and addr/data/rob_id held at 0.
- Distinct in-flight results never share a destination preg (rename guarantees this). The block does no same-preg checking.
- Reset values:
  - All FIFO counts and pointers 0, so `fu_ready` is all 1 from the first cycle after reset.
  - `rr_ptr = 0`.
  - All `we`, `cmpl_valid`, `addr`, `data` and `cmpl_rob_id` are 0.
- Reset mid-operation flushes all buffered results without writing them. This is required for pipeline flush.

## Timing
- Cycle t: `fu_valid && fu_ready`, captured at the edge ending t.
- Cycle t+1: the entry is at the FIFO head and is eligible for grant.
- Cycle t+2: `write_ports`/`cmpl` are valid; the register file commits at the end of t+2. Minimum latency is 2 cycles.
- Sustained throughput is `NUM_WRITE_PORTS` results per cycle.
- Fairness bound: a non-empty source is granted within `ceil(NUM_FU / NUM_WRITE_PORTS)` cycles.
- `fu_ready` drops in the cycle after the second un-popped enqueue.

## Structure
- `reg_pkg` contains:
  - `RegFileWritePort` (shared with the register file).
  - A new `WbEntry` typedef `{preg, data, rob_id}`.
  - `WB_FIFO_DEPTH = 2`.
- Sub-module `wb_skid_fifo`: a 2-entry FIFO of `WbEntry` with push, pop, full, empty and head. It is instantiated `NUM_FU` times.
- Top level contains the round-robin grant logic and the output registers.

## Test plan
- Single result: after reset, FU2 sends preg 17, data `0xDEAD`, rob 5 at cycle 0 → cycle 2 shows port0 `we=1`, addr 17, data `0xDEAD`, `cmpl_rob_id=5`; port1 `we=0`.
- Four simultaneous results with `rr_ptr=0`:
  - FU0..3 each push once at cycle 0.
  - Cycle 2: port0 = FU0, port1 = FU1.
  - Cycle 3: port0 = FU2, port1 = FU3.
  - `rr_ptr` then returns to 0.
- Back-pressure: FU0 pushes every cycle while FU1..3 also stream → FU0 FIFO fills, `fu_ready[0]` deasserts, and no FU0 result is lost or reordered (check the rob_id sequence).
- Fairness: all four sources permanently non-empty → every source is granted exactly once per 2 cycles over 100 cycles.
- Reset mid-stream: assert `rst` with 3 entries buffered → next cycle all `we=0`, `fu_ready` all 1, and the flushed entries never appear.
- Push/pop same cycle: FU1 count=1, pushes while granted → count stays 1, and the next grant returns the newer entry.
